// File: rtl/accum_col_ctrl.sv
// Read-modify-write front end for one accumulator column, with a full-column clear sweep.
// Optional build macro ACCUM_SAT_EN: an accumulate that carries out writes all-ones instead of wrapping.
module accum_col_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int MAX_OUT_ROWS = 1024,
  localparam int AW = $clog2(MAX_OUT_ROWS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  output logic                  busy,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic [AW-1:0]         inAddr,
  input  logic [DATA_WIDTH-1:0] inData,
  input  logic                  inAccum,
  output logic [AW-1:0]         rdAddr,
  input  logic [DATA_WIDTH-1:0] rdData,
  output logic                  wrEn,
  output logic [AW-1:0]         wrAddr,
  output logic [DATA_WIDTH-1:0] wrData,
  output logic                  ovf
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;
  localparam logic [AW-1:0] LAST_ADDR = AW'(MAX_OUT_ROWS - 1);

  logic [1:0]            r_state;
  logic                  r_s1Valid;
  logic                  r_s1InRange;
  logic [AW-1:0]         r_s1Addr;
  logic [DATA_WIDTH-1:0] r_s1Sum;
  logic [AW-1:0]         r_clrCnt;
  logic                  r_wrEn;
  logic [AW-1:0]         r_wrAddr;
  logic [DATA_WIDTH-1:0] r_wrData;
  logic                  r_ovf;

  logic                  w_accept;
  logic                  w_inRange;
  logic                  w_fwd;
  logic [DATA_WIDTH-1:0] w_operand;
  logic [DATA_WIDTH:0]   w_rawSum;
  logic                  w_carry;
  logic [DATA_WIDTH-1:0] w_sum;

  assign inReady   = (r_state == ST_RUN) && !clear;
  assign w_accept  = inValid && inReady;
  assign w_inRange = (32'(inAddr) < 32'(MAX_OUT_ROWS));
  assign rdAddr    = (r_state == ST_RUN) ? inAddr : '0;
  assign busy      = (r_state != ST_RUN) || r_s1Valid;

  // The previous accept has not reached the column yet, so a same-address hit takes its sum.
  assign w_fwd     = r_s1Valid && r_s1InRange && (r_s1Addr == inAddr);
  assign w_operand = w_fwd ? r_s1Sum : rdData;
  assign w_rawSum  = {1'b0, w_operand} + {1'b0, inData};
  assign w_carry   = inAccum && w_rawSum[DATA_WIDTH];

`ifdef ACCUM_SAT_EN
  assign w_sum = !inAccum ? inData : (w_carry ? '1 : w_rawSum[DATA_WIDTH-1:0]);
`else
  assign w_sum = inAccum ? w_rawSum[DATA_WIDTH-1:0] : inData;
`endif

  assign wrEn   = r_wrEn;
  assign wrAddr = r_wrAddr;
  assign wrData = r_wrData;
  assign ovf    = r_ovf;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_s1Valid   <= 1'b0;
      r_s1InRange <= 1'b0;
      r_s1Addr    <= '0;
      r_s1Sum     <= '0;
      r_clrCnt    <= '0;
      r_wrEn      <= 1'b0;
      r_wrAddr    <= '0;
      r_wrData    <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_s1Valid <= w_accept;
      r_wrEn    <= 1'b0;
      if (w_accept) begin
        r_s1Addr    <= inAddr;
        r_s1Sum     <= w_sum;
        r_s1InRange <= w_inRange;
        if (w_carry) r_ovf <= 1'b1;
      end
      // Write outputs are registered so they hold their last value whenever wrEn is low.
      case (r_state)
        ST_RUN: begin
          if (clear) r_state <= ST_DRAIN;
          if (w_accept && w_inRange) begin
            r_wrEn   <= 1'b1;
            r_wrAddr <= inAddr;
            r_wrData <= w_sum;
          end
        end
        ST_DRAIN: begin
          if (!r_s1Valid) begin
            r_state  <= ST_CLEAR;
            r_clrCnt <= '0;
            r_wrEn   <= 1'b1;
            r_wrAddr <= '0;
            r_wrData <= '0;
            r_ovf    <= 1'b0;
          end
        end
        ST_CLEAR: begin
          if (r_clrCnt == LAST_ADDR) begin
            r_state  <= ST_RUN;
            r_clrCnt <= '0;
          end else begin
            r_clrCnt <= r_clrCnt + AW'(1);
            r_wrEn   <= 1'b1;
            r_wrAddr <= r_clrCnt + AW'(1);
            r_wrData <= '0;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_accum_col_ctrl.sv
// Directed bench for accum_col_ctrl with a 12-row column model (rows 12..15 are out of range).
module tb_accum_col_ctrl;

  localparam int DW   = 8;
  localparam int ROWS = 12;
  localparam int AW   = $clog2(ROWS);

`ifdef ACCUM_SAT_EN
  localparam logic [7:0] OVF_DATA = 8'hFF;
`else
  localparam logic [7:0] OVF_DATA = 8'h10;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          clear;
  logic          busy;
  logic          inValid;
  logic          inReady;
  logic [AW-1:0] inAddr;
  logic [DW-1:0] inData;
  logic          inAccum;
  logic [AW-1:0] rdAddr;
  logic [DW-1:0] rdData;
  logic          wrEn;
  logic [AW-1:0] wrAddr;
  logic [DW-1:0] wrData;
  logic          ovf;

  logic [DW-1:0] mem [0:15];

  int numCompared   = 0;
  int numMismatched = 0;

  accum_col_ctrl #(.DATA_WIDTH(DW), .MAX_OUT_ROWS(ROWS)) dut (
    .clk(clk), .reset(reset), .clear(clear), .busy(busy),
    .inValid(inValid), .inReady(inReady), .inAddr(inAddr), .inData(inData), .inAccum(inAccum),
    .rdAddr(rdAddr), .rdData(rdData),
    .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Column storage model; row 13 is preset so the out-of-range path has a known read value.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
      mem[13] <= 8'h80;
    end else if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
  end
  assign rdData = mem[rdAddr];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    numCompared++;
    if (observed !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input logic acc, input logic clr);
    inValid = v;
    inAddr  = a;
    inData  = d;
    inAccum = acc;
    clear   = clr;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkWrite(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d);
    checkOutput({tag, ".wrEn"}, 32'(wrEn), 32'd1);
    checkOutput({tag, ".wrAddr"}, 32'(wrAddr), 32'(a));
    checkOutput({tag, ".wrData"}, 32'(wrData), 32'(d));
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    tick;
    tick;
    reset = 1'b0;
    checkOutput("rst.wrEn", 32'(wrEn), 32'd0);
    checkOutput("rst.wrAddr", 32'(wrAddr), 32'd0);
    checkOutput("rst.wrData", 32'(wrData), 32'd0);
    checkOutput("rst.ovf", 32'(ovf), 32'd0);
    checkOutput("rst.busy", 32'(busy), 32'd0);
    checkOutput("rst.inReady", 32'(inReady), 32'd1);

    // Overwrite then accumulate the same row two cycles later.
    applyStimulus(1'b1, 4'd5, 8'h10, 1'b0, 1'b0);
    tick;
    checkWrite("ow5", 4'd5, 8'h10);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    tick;
    checkOutput("ow5.idle.wrEn", 32'(wrEn), 32'd0);
    applyStimulus(1'b1, 4'd5, 8'h20, 1'b1, 1'b0);
    tick;
    checkWrite("acc5", 4'd5, 8'h30);
    checkOutput("acc5.ovf", 32'(ovf), 32'd0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    tick;

    // Back-to-back accumulates to row 7 need forwarding.
    applyStimulus(1'b1, 4'd7, 8'h01, 1'b1, 1'b0);
    checkOutput("fw.rdy1", 32'(inReady), 32'd1);
    tick;
    checkWrite("fw1", 4'd7, 8'h01);
    applyStimulus(1'b1, 4'd7, 8'h02, 1'b1, 1'b0);
    checkOutput("fw.rdy2", 32'(inReady), 32'd1);
    tick;
    checkWrite("fw2", 4'd7, 8'h03);
    applyStimulus(1'b1, 4'd7, 8'h03, 1'b1, 1'b0);
    checkOutput("fw.rdy3", 32'(inReady), 32'd1);
    tick;
    checkWrite("fw3", 4'd7, 8'h06);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    tick;
    checkOutput("fw.idle.wrEn", 32'(wrEn), 32'd0);
    checkOutput("fw.idle.busy", 32'(busy), 32'd0);

    // Overflow on accumulate, then an overwrite leaves the flag sticky.
    applyStimulus(1'b1, 4'd3, 8'hF0, 1'b0, 1'b0);
    tick;
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    tick;
    applyStimulus(1'b1, 4'd3, 8'h20, 1'b1, 1'b0);
    tick;
    checkWrite("ovf3", 4'd3, OVF_DATA);
    checkOutput("ovf3.ovf", 32'(ovf), 32'd1);
    applyStimulus(1'b1, 4'd3, 8'h01, 1'b0, 1'b0);
    tick;
    checkWrite("ow3", 4'd3, 8'h01);
    checkOutput("ow3.ovf", 32'(ovf), 32'd1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    tick;

    // Accept to row 2, then clear on the next cycle: pending write, one drain cycle, full sweep.
    applyStimulus(1'b1, 4'd2, 8'h55, 1'b0, 1'b0);
    tick;
    applyStimulus(1'b1, 4'd9, 8'h11, 1'b0, 1'b1);
    checkOutput("clr.req.inReady", 32'(inReady), 32'd0);
    checkWrite("clr.pend", 4'd2, 8'h55);
    tick;
    applyStimulus(1'b1, 4'd9, 8'h11, 1'b0, 1'b0);
    checkOutput("clr.drain.wrEn", 32'(wrEn), 32'd0);
    checkOutput("clr.drain.busy", 32'(busy), 32'd1);
    checkOutput("clr.drain.inReady", 32'(inReady), 32'd0);
    tick;
    for (int i = 0; i < ROWS; i++) begin
      checkWrite("clr.sweep", 4'(i), 8'h00);
      checkOutput("clr.sweep.inReady", 32'(inReady), 32'd0);
      checkOutput("clr.sweep.busy", 32'(busy), 32'd1);
      checkOutput("clr.sweep.ovf", 32'(ovf), 32'd0);
      tick;
    end
    checkOutput("clr.done.wrEn", 32'(wrEn), 32'd0);
    checkOutput("clr.done.inReady", 32'(inReady), 32'd1);
    checkOutput("clr.done.busy", 32'(busy), 32'd0);
    checkOutput("clr.mem2", 32'(mem[2]), 32'd0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);

    // Clear and inValid together: clear wins; then reset lands mid-sweep.
    applyStimulus(1'b1, 4'd4, 8'h77, 1'b0, 1'b1);
    checkOutput("col.inReady", 32'(inReady), 32'd0);
    tick;
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("col.drain.wrEn", 32'(wrEn), 32'd0);
    tick;
    for (int i = 0; i < 8; i++) tick;
    checkWrite("col.cnt8", 4'd8, 8'h00);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    #1;
    checkOutput("midrst.wrEn", 32'(wrEn), 32'd0);
    checkOutput("midrst.busy", 32'(busy), 32'd0);
    checkOutput("midrst.inReady", 32'(inReady), 32'd1);

    // Out-of-range row 13 (preset 0x80): no writes, and the second accept must not forward.
    applyStimulus(1'b1, 4'd13, 8'h70, 1'b1, 1'b0);
    checkOutput("oor1.inReady", 32'(inReady), 32'd1);
    tick;
    checkOutput("oor1.wrEn", 32'(wrEn), 32'd0);
    checkOutput("oor1.busy", 32'(busy), 32'd1);
    applyStimulus(1'b1, 4'd13, 8'h20, 1'b1, 1'b0);
    tick;
    checkOutput("oor2.wrEn", 32'(wrEn), 32'd0);
    checkOutput("oor2.ovf", 32'(ovf), 32'd0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    tick;
    checkOutput("oor.idle.busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
